seg7_scan_driver: RTL

Time-multiplexed driver for an N-digit common-anode 7-segment display. Takes a packed vector of 4-bit digit codes plus per-digit blank, blink and decimal-point masks, and scans one digit per slot with full hex decode, leading-zero suppression, anti-ghosting dead time and tear-free frame snapshots. It is the parametrised multi-digit successor to the single-digit decoder used in the digital clock, and sits between the clock/counter datapath and the board's segment and anode pins.

---
 rtl/seg7_pkg.sv | 55 +++++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, glyph table and helpers for the multiplexed 7-segment driver.
// Glyphs are active-low {a,b,c,d,e,f,g} with segment a in bit 6.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  localparam int N_DIGITS_MIN = 1;
  localparam int N_DIGITS_MAX = 8;

  function automatic logic n_digits_ok(input int n);
    return (n >= N_DIGITS_MIN) && (n <= N_DIGITS_MAX);
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = GLYPH_A;
      4'hB:    seg = GLYPH_B;
      4'hC:    seg = GLYPH_C;
      4'hD:    seg = GLYPH_D;
      4'hE:    seg = GLYPH_E;
      4'hF:    seg = GLYPH_F;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low segment pattern decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the selected digit.
  always_comb begin
    seg = hex_to_seg(hex);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-frame input
// snapshots, blinking, leading-zero suppression and per-slot dead time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 50000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    lz_en,
  input  logic [4*N_DIGITS-1:0]   digits_i,
  input  logic [N_DIGITS-1:0]     blank_i,
  input  logic [N_DIGITS-1:0]     blink_i,
  input  logic [N_DIGITS-1:0]     dp_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    frame_o
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_DEAD = PW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  generate
    if (!n_digits_ok(N_DIGITS)) begin : g_bad_n_digits
      $error("seg7_scan_driver: N_DIGITS must be in 1..8");
    end
  endgenerate

  logic [PW-1:0]             pre_r;
  logic [IW-1:0]             idx_r;
  logic [FW-1:0]             frame_cnt_r;
  logic                      phase_r;
  logic [N_DIGITS-1:0][3:0]  digits_r;
  logic [N_DIGITS-1:0]       blank_r;
  logic [N_DIGITS-1:0]       blink_r;
  logic [N_DIGITS-1:0]       dp_r;
  logic                      lz_r;

  logic                      tick_s;
  logic                      snap_s;
  logic                      lead_s;
  logic [N_DIGITS-1:0]       supp_s;
  logic [3:0]                cur_digit_s;
  logic [6:0]                glyph_s;
  logic                      blanked_s;
  logic                      visible_s;
  logic [N_DIGITS-1:0]       an_s;

  assign tick_s = (pre_r == PRE_LAST);
  assign snap_s = tick_s && (idx_r == IDX_LAST);

  // Slot prescaler and scan index.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= {PW{1'b0}};
      idx_r <= {IW{1'b0}};
    end else if (tick_s) begin
      pre_r <= {PW{1'b0}};
      idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + 1'b1;
    end else begin
      pre_r <= pre_r + 1'b1;
      idx_r <= idx_r;
    end
  end

  // Frame snapshot of the inputs and the blink frame counter; both advance only
  // at the frame boundary so a frame is never torn.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_r    <= {(4*N_DIGITS){1'b0}};
      blank_r     <= {N_DIGITS{1'b1}};
      blink_r     <= {N_DIGITS{1'b0}};
      dp_r        <= {N_DIGITS{1'b0}};
      lz_r        <= 1'b0;
      frame_cnt_r <= {FW{1'b0}};
      phase_r     <= 1'b0;
    end else if (snap_s) begin
      digits_r <= digits_i;
      blank_r  <= blank_i;
      blink_r  <= blink_i;
      dp_r     <= dp_i;
      lz_r     <= lz_en;
      if (frame_cnt_r == FRM_LAST) begin
        frame_cnt_r <= {FW{1'b0}};
        phase_r     <= ~phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + 1'b1;
        phase_r     <= phase_r;
      end
    end else begin
      digits_r    <= digits_r;
      blank_r     <= blank_r;
      blink_r     <= blink_r;
      dp_r        <= dp_r;
      lz_r        <= lz_r;
      frame_cnt_r <= frame_cnt_r;
      phase_r     <= phase_r;
    end
  end

  // Leading-zero run from the most significant digit; digit 0 always shows.
  always_comb begin
    supp_s = {N_DIGITS{1'b0}};
    lead_s = lz_r;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (lead_s && (digits_r[k] == 4'h0)) begin
        supp_s[k] = 1'b1;
      end else begin
        lead_s = 1'b0;
      end
    end
  end

  // Visibility of the current slot and the anode pattern it implies.
  always_comb begin
    cur_digit_s = digits_r[idx_r];
    blanked_s   = blank_r[idx_r] | (phase_r & blink_r[idx_r]) | supp_s[idx_r];
    visible_s   = en & (pre_r >= PRE_DEAD) & ~blanked_s;
    an_s        = {N_DIGITS{1'b1}};
    for (int k = 0; k < N_DIGITS; k++) begin
      if (visible_s && (idx_r == IW'(k))) begin
        an_s[k] = 1'b0;
      end else begin
        an_s[k] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .hex (cur_digit_s),
    .seg (glyph_s)
  );

  // Registered pin drivers; dark whenever the slot is not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_o   <= SEG_OFF;
      dp_o    <= 1'b1;
      an_o    <= {N_DIGITS{1'b1}};
      frame_o <= 1'b0;
    end else begin
      seg_o   <= visible_s ? glyph_s : SEG_OFF;
      dp_o    <= ~(visible_s & dp_r[idx_r]);
      an_o    <= an_s;
      frame_o <= snap_s;
    end
  end

endmodule
